uart_tx_stage: RTL and testbench
================================

# uart_tx_stage

Serial output stage downstream of the memory stage. It accepts the 8-bit result stream on a valid/ready handshake and buffers it in a small FIFO. It then transmits each byte off-chip as an 8N1 asynchronous serial frame (start bit, 8 data bits LSB first, stop bit). It is the last sequential stage before the pad ring.

## Interface

Parameters:
- CLKS_PER_BIT, 16: clock cycles per serial bit; integer ≥ 2.
- FIFO_DEPTH, 8: byte entries in the input FIFO; power of two, ≥ 2.

Ports:
- clk_i  in  1  single clock; all logic on rising edge.
- res_i  in  1  synchronous, active-high reset.
- data_i  in  8  byte from the upstream memory stage.
- valid_i  in  1  data_i is valid this cycle.
- ready_o  out  1  FIFO can accept a byte this cycle (FIFO not full).
- tx_o  out  1  serial line; idles high.
- busy_o  out  1  high while a frame is in flight or the FIFO is non-empty.
- level_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy, 0..FIFO_DEPTH.
- drop_o  out  1  one-cycle pulse when a byte is presented while full and discarded.

## Operation

- Write: on an edge with valid_i && ready_o, data_i is pushed.
- ready_o is low whenever level_o == FIFO_DEPTH, regardless of a same-cycle pop. No write-through when full.
- Drop: on an edge with valid_i && !ready_o, the byte is discarded and drop_o is high for the following cycle only. FIFO contents are unchanged.
- FIFO pointers wrap modulo FIFO_DEPTH. level_o changes +1 on write only, −1 on pop only, and is unchanged on simultaneous write and pop.
- TX FSM states are IDLE, START, DATA, STOP:
  - IDLE: tx_o = 1. If the FIFO is non-empty, pop the head into the shift register, clear the baud counter, and go to START.
  - START: tx_o = 0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx_o = shift_reg[bit index] for CLKS_PER_BIT cycles per bit. Bit index runs 0..7; after bit 7, go to STOP.
  - STOP: tx_o = 1 for CLKS_PER_BIT cycles. On the last cycle, if the FIFO is non-empty, pop and go directly to START with no idle gap; otherwise go to IDLE.
- tx_o is registered and glitch-free.
- busy_o = (state != IDLE) || (level_o != 0).
- Reset values: tx_o = 1, ready_o = 1, busy_o = 0, level_o = 0, drop_o = 0, FSM in IDLE, all counters 0.

## Timing

- Byte written at edge k into an empty FIFO with the FSM in IDLE:
  - level_o = 1 after edge k.
  - Pop at edge k+1; level_o = 0 and tx_o = 0 after edge k+1.
- Frame length is exactly 10·CLKS_PER_BIT cycles from the tx_o falling edge to the end of the stop bit.
- Back-to-back frames: a start bit follows the stop bit on the next cycle. Continuous traffic gives 10·CLKS_PER_BIT cycles per byte.
- A byte written during the last STOP cycle is not visible to that cycle's pop decision. It is popped from IDLE one cycle later, leaving a 1-cycle idle-high gap.
- Reset mid-frame: after the reset edge, tx_o = 1, the FIFO is empty, and the frame is aborted. A truncated frame on the line is acceptable.
- Reset has priority over a simultaneous write or pop.
- busy_o falls on the cycle after the last STOP cycle of the final queued byte.

## Test plan

Benches use CLKS_PER_BIT = 4 and FIFO_DEPTH = 4.

- Reset, then 50 idle cycles -> tx_o = 1, ready_o = 1, busy_o = 0, level_o = 0, drop_o = 0 throughout.
- Single byte 0xA5 -> tx_o low 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then high 4 cycles (40 cycles total); busy_o low on the next cycle.
- valid_i held for 6 consecutive cycles with 0x01..0x06 -> level_o sequence 1,1,2,3,4. On the sixth cycle ready_o = 0 and drop_o pulses once. 0x01..0x05 are sent as 5 contiguous frames over 200 cycles; 0x06 never appears on tx_o.
- 0x3C transmitting with 0x11 and 0x22 queued; assert res_i during data bit 3 -> next cycle tx_o = 1, level_o = 0, busy_o = 0; no further frames.
- Write 0x7E during the last STOP cycle of a prior frame with the FIFO otherwise empty -> exactly one idle-high cycle, then the 0x7E start bit.
- Random valid_i over 2000 bytes with ready_o honoured -> bytes decoded from tx_o match the accepted input order exactly; drop_o never asserts.

Source files
------------

// File: rtl/uart_tx_stage.sv
// Byte FIFO feeding an 8N1 serial transmitter; last sequential stage before the pads.
// The FIFO head is read combinationally so a byte can leave IDLE/STOP on the same edge it is popped.
module uart_tx_stage #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk_i,
    input  logic                          res_i,
    input  logic [7:0]                    data_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    output logic                          tx_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          drop_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] LVL_ONE   = LVL_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // ---------------------------------------------------------------
    // FIFO storage and bookkeeping
    // ---------------------------------------------------------------
    logic [7:0]       mem_reg [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [LVL_W-1:0] level_reg;
    logic             drop_reg;

    // ---------------------------------------------------------------
    // Transmitter state
    // ---------------------------------------------------------------
    state_t           state_reg;
    logic [CNT_W-1:0] baud_cnt_reg;
    logic [2:0]       bit_idx_reg;
    logic [7:0]       shift_reg;
    logic             tx_reg;

    logic             fifo_full;
    logic             fifo_empty;
    logic             baud_last;
    logic             push;
    logic             pop;
    logic [7:0]       head_data;

    assign fifo_full  = (level_reg == LVL_FULL);
    assign fifo_empty = (level_reg == '0);
    assign baud_last  = (baud_cnt_reg == BAUD_LAST);
    assign head_data  = mem_reg[rd_ptr_reg];

    // Pop decisions look only at the registered level, so a byte written on
    // the same edge is never seen until the following cycle.
    always_comb begin
        push = valid_i && !fifo_full;
        pop  = 1'b0;
        if (!fifo_empty) begin
            if (state_reg == IDLE)
                pop = 1'b1;
            else if (state_reg == STOP && baud_last)
                pop = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!res_i && push)
            mem_reg[wr_ptr_reg] <= data_i;
    end

    always_ff @(posedge clk_i) begin
        if (res_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            drop_reg   <= 1'b0;
        end else begin
            drop_reg <= valid_i && fifo_full;
            if (push)
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            case ({push, pop})
                2'b10:   level_reg <= level_reg + LVL_ONE;
                2'b01:   level_reg <= level_reg - LVL_ONE;
                default: level_reg <= level_reg;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Frame sequencer; tx_reg is loaded with the value of the next cycle
    // ---------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (res_i) begin
            state_reg    <= IDLE;
            baud_cnt_reg <= '0;
            bit_idx_reg  <= '0;
            shift_reg    <= '0;
            tx_reg       <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    tx_reg <= 1'b1;
                    if (pop) begin
                        shift_reg    <= head_data;
                        baud_cnt_reg <= '0;
                        state_reg    <= START;
                        tx_reg       <= 1'b0;
                    end
                end
                START: begin
                    if (baud_last) begin
                        baud_cnt_reg <= '0;
                        bit_idx_reg  <= '0;
                        state_reg    <= DATA;
                        tx_reg       <= shift_reg[0];
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + CNT_ONE;
                    end
                end
                DATA: begin
                    if (baud_last) begin
                        baud_cnt_reg <= '0;
                        if (bit_idx_reg == 3'd7) begin
                            bit_idx_reg <= '0;
                            state_reg   <= STOP;
                            tx_reg      <= 1'b1;
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 3'd1;
                            tx_reg      <= shift_reg[bit_idx_reg + 3'd1];
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + CNT_ONE;
                    end
                end
                STOP: begin
                    if (baud_last) begin
                        baud_cnt_reg <= '0;
                        if (pop) begin
                            // Chain straight into the next start bit, no idle gap
                            shift_reg <= head_data;
                            state_reg <= START;
                            tx_reg    <= 1'b0;
                        end else begin
                            state_reg <= IDLE;
                            tx_reg    <= 1'b1;
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + CNT_ONE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    tx_reg    <= 1'b1;
                end
            endcase
        end
    end

    assign ready_o = !fifo_full;
    assign tx_o    = tx_reg;
    assign busy_o  = (state_reg != IDLE) || !fifo_empty;
    assign level_o = level_reg;
    assign drop_o  = drop_reg;

endmodule

// File: tb/tb_uart_tx_stage.sv
// Directed bench for uart_tx_stage with CLKS_PER_BIT = 4 and FIFO_DEPTH = 4.
// A line monitor decodes frames from tx_o by mid-bit sampling.
module tb_uart_tx_stage;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk_i = 1'b0;
    logic       res_i = 1'b0;
    logic [7:0] data_i = 8'h00;
    logic       valid_i = 1'b0;
    logic       ready_o;
    logic       tx_o;
    logic       busy_o;
    logic [2:0] level_o;
    logic       drop_o;

    int checks = 0;
    int errors = 0;

    uart_tx_stage #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk_i  (clk_i),
        .res_i  (res_i),
        .data_i (data_i),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .tx_o   (tx_o),
        .busy_o (busy_o),
        .level_o(level_o),
        .drop_o (drop_o)
    );

    always #5 clk_i = ~clk_i;

    // ---------------- line monitor ----------------
    logic       mon_en = 1'b0;
    logic       mon_active = 1'b0;
    int         mon_cnt = 0;
    int         cyc = 0;
    int         mon_start = 0;
    int         stop_errs = 0;
    logic [7:0] mon_byte;
    logic [7:0] q_got[$];
    int         q_start[$];

    always @(negedge clk_i) begin
        cyc = cyc + 1;
        if (!mon_en || res_i) begin
            mon_active = 1'b0;
        end else if (!mon_active) begin
            if (tx_o == 1'b0) begin
                mon_active = 1'b1;
                mon_cnt    = 0;
                mon_start  = cyc;
            end
        end else begin
            mon_cnt = mon_cnt + 1;
            if (mon_cnt >= 6 && mon_cnt <= 34 && (mon_cnt % CPB) == 2)
                mon_byte[(mon_cnt - 6) / CPB] = tx_o;
            if (mon_cnt == 38) begin
                if (tx_o !== 1'b1)
                    stop_errs = stop_errs + 1;
                q_got.push_back(mon_byte);
                q_start.push_back(mon_start);
                mon_active = 1'b0;
            end
        end
    end

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n;
        n = 0;
        while (busy_o && n < limit) begin
            tick();
            n++;
        end
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL %s: busy_o still %b after %0d cycles, required 0", name, busy_o, limit);
        end
        tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        int bad;
        res_i   = 1'b1;
        valid_i = 1'b0;
        tick();
        tick();
        res_i = 1'b0;
        bad = 0;
        for (int c = 0; c < 50; c++) begin
            tick();
            checks++;
            if (tx_o !== 1'b1 || ready_o !== 1'b1 || busy_o !== 1'b0 ||
                level_o !== 3'd0 || drop_o !== 1'b0) begin
                errors++;
                bad++;
                if (bad < 5)
                    $display("FAIL reset_idle cycle %0d: tx=%b ready=%b busy=%b level=%0d drop=%b, required 1 1 0 0 0",
                             c, tx_o, ready_o, busy_o, level_o, drop_o);
            end
        end
        $display("test_reset: 50 idle cycles checked");
    endtask

    task automatic test_single_byte;
        logic [7:0] b;
        logic       exp_tx;
        int         slot;
        b = 8'hA5;
        q_got.delete();
        q_start.delete();
        valid_i = 1'b1;
        data_i  = b;
        tick();
        valid_i = 1'b0;
        checks++;
        if (level_o !== 3'd1 || tx_o !== 1'b1) begin
            errors++;
            $display("FAIL single_write: level=%0d tx=%b, required level=1 tx=1", level_o, tx_o);
        end
        for (int c = 0; c < 10 * CPB; c++) begin
            tick();
            slot = c / CPB;
            if (slot == 0)
                exp_tx = 1'b0;
            else if (slot == 9)
                exp_tx = 1'b1;
            else
                exp_tx = b[slot - 1];
            checks++;
            if (tx_o !== exp_tx || busy_o !== 1'b1) begin
                errors++;
                $display("FAIL single_wave cycle %0d: tx=%b busy=%b, required tx=%b busy=1",
                         c, tx_o, busy_o, exp_tx);
            end
            if (c == 0) begin
                checks++;
                if (level_o !== 3'd0) begin
                    errors++;
                    $display("FAIL single_pop: level=%0d, required 0", level_o);
                end
            end
        end
        tick();
        checks++;
        if (busy_o !== 1'b0 || tx_o !== 1'b1) begin
            errors++;
            $display("FAIL single_busy_fall: busy=%b tx=%b, required busy=0 tx=1", busy_o, tx_o);
        end
        checks++;
        if (q_got.size() != 1 || stop_errs != 0) begin
            errors++;
            $display("FAIL single_decode: %0d frames, %0d stop errors, required 1 frame 0 errors",
                     q_got.size(), stop_errs);
        end else begin
            checks++;
            if (q_got[0] !== b) begin
                errors++;
                $display("FAIL single_decode_value: got %h, required %h", q_got[0], b);
            end
        end
        $display("test_single_byte: sent %h", b);
    endtask

    task automatic test_overflow;
        logic [2:0] exp_level [6];
        int         cnt;
        exp_level = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
        q_got.delete();
        q_start.delete();
        for (int i = 0; i < 6; i++) begin
            valid_i = 1'b1;
            data_i  = 8'(i + 1);
            checks++;
            if (ready_o !== (i < 5)) begin
                errors++;
                $display("FAIL ovf_ready cycle %0d: ready=%b, required %b", i, ready_o, (i < 5));
            end
            tick();
            checks++;
            if (level_o !== exp_level[i] || drop_o !== (i == 5)) begin
                errors++;
                $display("FAIL ovf_level cycle %0d: level=%0d drop=%b, required level=%0d drop=%b",
                         i, level_o, drop_o, exp_level[i], (i == 5));
            end
        end
        valid_i = 1'b0;
        tick();
        checks++;
        if (drop_o !== 1'b0) begin
            errors++;
            $display("FAIL ovf_drop_pulse: drop=%b, required 0", drop_o);
        end
        cnt = 7;
        while (busy_o && cnt < 600) begin
            tick();
            cnt++;
        end
        checks++;
        if (cnt != 202) begin
            errors++;
            $display("FAIL ovf_duration: busy fell after edge %0d, required 202", cnt);
        end
        checks++;
        if (q_got.size() != 5 || stop_errs != 0) begin
            errors++;
            $display("FAIL ovf_frames: %0d frames %0d stop errors, required 5 frames 0 errors",
                     q_got.size(), stop_errs);
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (q_got[i] !== 8'(i + 1)) begin
                    errors++;
                    $display("FAIL ovf_byte %0d: got %h, required %h", i, q_got[i], 8'(i + 1));
                end
                if (i > 0) begin
                    checks++;
                    if (q_start[i] - q_start[i-1] != 10 * CPB) begin
                        errors++;
                        $display("FAIL ovf_spacing %0d: %0d cycles, required %0d",
                                 i, q_start[i] - q_start[i-1], 10 * CPB);
                    end
                end
            end
        end
        tick();
        $display("test_overflow: 0x01..0x05 sent, 0x06 dropped");
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] bytes [3];
        int         lows;
        int         busys;
        bytes  = '{8'h3C, 8'h11, 8'h22};
        mon_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            valid_i = 1'b1;
            data_i  = bytes[i];
            tick();
        end
        valid_i = 1'b0;
        for (int i = 0; i < 16; i++)
            tick();
        checks++;
        if (tx_o !== 1'b1 || level_o !== 3'd2) begin
            errors++;
            $display("FAIL rst_mid_bit3: tx=%b level=%0d, required tx=1 level=2", tx_o, level_o);
        end
        res_i = 1'b1;
        tick();
        res_i = 1'b0;
        checks++;
        if (tx_o !== 1'b1 || level_o !== 3'd0 || busy_o !== 1'b0 || ready_o !== 1'b1 || drop_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_after: tx=%b level=%0d busy=%b ready=%b drop=%b, required 1 0 0 1 0",
                     tx_o, level_o, busy_o, ready_o, drop_o);
        end
        lows  = 0;
        busys = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (tx_o !== 1'b1) lows++;
            if (busy_o !== 1'b0) busys++;
        end
        checks++;
        if (lows != 0 || busys != 0) begin
            errors++;
            $display("FAIL rst_mid_quiet: %0d low cycles %0d busy cycles, required 0 0", lows, busys);
        end
        mon_en = 1'b1;
        $display("test_reset_mid_frame: frame aborted, queue flushed");
    endtask

    task automatic test_stop_write;
        q_got.delete();
        q_start.delete();
        valid_i = 1'b1;
        data_i  = 8'h96;
        tick();
        valid_i = 1'b0;
        for (int i = 0; i < 10 * CPB; i++)
            tick();
        checks++;
        if (tx_o !== 1'b1 || busy_o !== 1'b1 || level_o !== 3'd0) begin
            errors++;
            $display("FAIL stopw_last_stop: tx=%b busy=%b level=%0d, required 1 1 0", tx_o, busy_o, level_o);
        end
        valid_i = 1'b1;
        data_i  = 8'h7E;
        tick();
        valid_i = 1'b0;
        checks++;
        if (tx_o !== 1'b1 || level_o !== 3'd1 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL stopw_gap: tx=%b level=%0d busy=%b, required 1 1 1", tx_o, level_o, busy_o);
        end
        tick();
        checks++;
        if (tx_o !== 1'b0 || level_o !== 3'd0) begin
            errors++;
            $display("FAIL stopw_start: tx=%b level=%0d, required 0 0", tx_o, level_o);
        end
        wait_idle("stopw_drain", 100);
        checks++;
        if (q_got.size() != 2 || stop_errs != 0) begin
            errors++;
            $display("FAIL stopw_frames: %0d frames %0d stop errors, required 2 0", q_got.size(), stop_errs);
        end else begin
            checks++;
            if (q_got[0] !== 8'h96 || q_got[1] !== 8'h7E || q_start[1] - q_start[0] != 10 * CPB + 1) begin
                errors++;
                $display("FAIL stopw_decode: got %h %h spacing %0d, required 96 7e spacing %0d",
                         q_got[0], q_got[1], q_start[1] - q_start[0], 10 * CPB + 1);
            end
        end
        $display("test_stop_write: 7e followed after one idle cycle");
    endtask

    task automatic test_random;
        logic [7:0] q_exp[$];
        int         accepted;
        int         drops;
        int         n;
        q_got.delete();
        q_start.delete();
        accepted = 0;
        drops    = 0;
        n        = 0;
        while (accepted < 2000 && n < 90000) begin
            if (ready_o && $urandom_range(0, 7) == 0) begin
                valid_i = 1'b1;
                data_i  = 8'($urandom_range(0, 255));
                q_exp.push_back(data_i);
                accepted++;
            end else begin
                valid_i = 1'b0;
                data_i  = 8'($urandom_range(0, 255));
            end
            tick();
            if (drop_o) drops++;
            n++;
        end
        valid_i = 1'b0;
        checks++;
        if (accepted != 2000) begin
            errors++;
            $display("FAIL rand_budget: accepted %0d bytes, required 2000", accepted);
        end
        wait_idle("rand_drain", 400);
        checks++;
        if (drops != 0 || stop_errs != 0) begin
            errors++;
            $display("FAIL rand_drop: %0d drops %0d stop errors, required 0 0", drops, stop_errs);
        end
        checks++;
        if (q_got.size() != q_exp.size()) begin
            errors++;
            $display("FAIL rand_count: decoded %0d, required %0d", q_got.size(), q_exp.size());
        end else begin
            for (int i = 0; i < q_exp.size(); i++) begin
                checks++;
                if (q_got[i] !== q_exp[i]) begin
                    errors++;
                    $display("FAIL rand_byte %0d: got %h, required %h", i, q_got[i], q_exp[i]);
                end
            end
        end
        $display("test_random: %0d bytes accepted, %0d decoded", accepted, q_got.size());
    endtask

    initial begin
        test_reset();
        mon_en = 1'b1;
        test_single_byte();
        test_overflow();
        test_reset_mid_frame();
        test_stop_write();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
